// File: rtl/counter_seq.sv
// counter_seq: programs one counter block (START/STEP strobes), enables it,
// issues NPULSES triggers spaced PERIOD cycles apart, then disables it and
// reports completion. Every output is a flop; the shadows capture the
// programming inputs on an accepted arm so later input changes are inert.
module counter_seq (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        arm_i,
  input  logic        abort_i,
  input  logic [31:0] START,
  input  logic [31:0] STEP,
  input  logic [31:0] PERIOD,
  input  logic [31:0] NPULSES,
  input  logic        DIR,
  input  logic        carry_i,
  output logic        cnt_enable_o,
  output logic        cnt_trigger_o,
  output logic        cnt_dir_o,
  output logic [31:0] cnt_start_o,
  output logic        cnt_start_wstb_o,
  output logic [31:0] cnt_step_o,
  output logic        cnt_step_wstb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        carry_seen_o,
  output logic [31:0] pulse_count_o
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_START = 3'd1,
    LD_STEP  = 3'd2,
    ENA      = 3'd3,
    RUN      = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t        state_q, state_d;

  // Shadows not visible on ports
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] npulses_q, npulses_d;
  logic [DW-1:0] per_cnt_q, per_cnt_d;

  // Next values for the registered outputs
  logic [DW-1:0] start_d, step_d, pulse_count_d;
  logic          dir_d;
  logic          enable_d, trigger_d, start_wstb_d, step_wstb_d;
  logic          busy_d, done_d, aborted_d, carry_seen_d;
  logic [DW-1:0] reload;

  // Trigger spacing reload value; PERIOD of 0 behaves as 1
  assign reload = (period_q == '0) ? '0 : period_q - DW'(1);

  // State register and all registered outputs/shadows
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= IDLE;
      period_q         <= '0;
      npulses_q        <= '0;
      per_cnt_q        <= '0;
      cnt_start_o      <= '0;
      cnt_step_o       <= '0;
      cnt_dir_o        <= 1'b0;
      cnt_enable_o     <= 1'b0;
      cnt_trigger_o    <= 1'b0;
      cnt_start_wstb_o <= 1'b0;
      cnt_step_wstb_o  <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      aborted_o        <= 1'b0;
      carry_seen_o     <= 1'b0;
      pulse_count_o    <= '0;
    end else begin
      state_q          <= state_d;
      period_q         <= period_d;
      npulses_q        <= npulses_d;
      per_cnt_q        <= per_cnt_d;
      cnt_start_o      <= start_d;
      cnt_step_o       <= step_d;
      cnt_dir_o        <= dir_d;
      cnt_enable_o     <= enable_d;
      cnt_trigger_o    <= trigger_d;
      cnt_start_wstb_o <= start_wstb_d;
      cnt_step_wstb_o  <= step_wstb_d;
      busy_o           <= busy_d;
      done_o           <= done_d;
      aborted_o        <= aborted_d;
      carry_seen_o     <= carry_seen_d;
      pulse_count_o    <= pulse_count_d;
    end
  end

  // Next-state, trigger scheduling and next-output decode
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    npulses_d     = npulses_q;
    per_cnt_d     = per_cnt_q;
    start_d       = cnt_start_o;
    step_d        = cnt_step_o;
    dir_d         = cnt_dir_o;
    pulse_count_d = pulse_count_o;
    carry_seen_d  = carry_seen_o | (cnt_enable_o & carry_i);
    aborted_d     = 1'b0;
    trigger_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Abort in IDLE is a no-op but still suppresses a coincident arm
        if (arm_i && !abort_i) begin
          start_d       = START;
          step_d        = STEP;
          period_d      = PERIOD;
          npulses_d     = NPULSES;
          dir_d         = DIR;
          pulse_count_d = '0;
          carry_seen_d  = 1'b0;
          state_d       = (NPULSES == '0) ? FIN : LD_START;
        end
      end
      LD_START: state_d = LD_STEP;
      LD_STEP:  state_d = ENA;
      ENA:      state_d = RUN;
      RUN: begin
        // Leave once the trigger that reached the programmed count is out
        if (cnt_trigger_o && (pulse_count_o == npulses_q)) begin
          state_d = FIN;
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if ((state_q != IDLE) && abort_i) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end

    // First RUN cycle always triggers; later ones when the down-counter hits 0
    if (state_d == RUN) begin
      if ((state_q == ENA) || (per_cnt_q == '0)) begin
        trigger_d = 1'b1;
        per_cnt_d = reload;
      end else begin
        per_cnt_d = per_cnt_q - DW'(1);
      end
    end

    if (trigger_d) begin
      pulse_count_d = pulse_count_o + DW'(1);
    end

    start_wstb_d = (state_d == LD_START);
    step_wstb_d  = (state_d == LD_STEP);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
    enable_d     = (state_d == ENA) || (state_d == RUN) ||
                   ((state_d == FIN) && (state_q == RUN));
  end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a small behavioural counter attached.
module tb_counter_seq;

  logic        clk;
  logic        reset_n;
  logic        arm, abort;
  logic [31:0] start_v, step_v, period_v, npulses_v;
  logic        dir_v;
  logic        carry;
  logic        enable, trigger, cdir, start_wstb, step_wstb;
  logic [31:0] cstart, cstep, pulse_count;
  logic        busy, done, aborted, carry_seen;

  int total = 0;
  int bad   = 0;

  // Behavioural counter driven by the sequencer
  logic [31:0] out_m, step_m;

  counter_seq dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .arm_i            (arm),
    .abort_i          (abort),
    .START            (start_v),
    .STEP             (step_v),
    .PERIOD           (period_v),
    .NPULSES          (npulses_v),
    .DIR              (dir_v),
    .carry_i          (carry),
    .cnt_enable_o     (enable),
    .cnt_trigger_o    (trigger),
    .cnt_dir_o        (cdir),
    .cnt_start_o      (cstart),
    .cnt_start_wstb_o (start_wstb),
    .cnt_step_o       (cstep),
    .cnt_step_wstb_o  (step_wstb),
    .busy_o           (busy),
    .done_o           (done),
    .aborted_o        (aborted),
    .carry_seen_o     (carry_seen),
    .pulse_count_o    (pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: loads on strobes, steps on enabled triggers, flags wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_m  <= '0;
      step_m <= '0;
      carry  <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (step_wstb) step_m <= cstep;
      if (start_wstb) begin
        out_m <= cstart;
      end else if (enable && trigger) begin
        if (!cdir) {carry, out_m} <= {1'b0, out_m} + {1'b0, step_m};
        else       {carry, out_m} <= {1'b0, out_m} - {1'b0, step_m};
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] s, input logic [31:0] st,
                      input logic [31:0] p, input logic [31:0] n, input logic d);
    start_v = s; step_v = st; period_v = p; npulses_v = n; dir_v = d;
  endtask

  // Arm pulse; returns in cycle 1 of the sequence
  task automatic do_arm;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    load(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #3;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_enable", enable, 1'b0);
    chk32("rst_start", cstart, 32'd0);
    chk32("rst_count", pulse_count, 32'd0);
    #9 reset_n = 1'b1;
    tick(1);

    // Basic sequence, with an ignored arm and input changes mid-run
    load(32'd10, 32'd2, 32'd4, 32'd3, 1'b0);
    do_arm();
    chk1("s1_start_wstb", start_wstb, 1'b1);
    chk1("s1_busy_c1", busy, 1'b1);
    chk1("s1_enable_c1", enable, 1'b0);
    chk32("s1_cnt_start", cstart, 32'd10);
    tick(1);
    chk1("s1_step_wstb", step_wstb, 1'b1);
    chk1("s1_start_wstb_c2", start_wstb, 1'b0);
    chk32("s1_cnt_step", cstep, 32'd2);
    tick(1);
    chk1("s1_enable_c3", enable, 1'b1);
    chk1("s1_trig_c3", trigger, 1'b0);
    chk1("s1_step_wstb_c3", step_wstb, 1'b0);
    tick(1);
    for (int c = 4; c <= 14; c++) begin
      chk1($sformatf("s1_trig_c%0d", c), trigger, (c == 4) || (c == 8) || (c == 12));
      chk1($sformatf("s1_done_c%0d", c), done, c == 13);
      chk1($sformatf("s1_enable_c%0d", c), enable, c <= 13);
      chk1($sformatf("s1_busy_c%0d", c), busy, c <= 13);
      if (c == 6) begin
        arm = 1'b1;
        load(32'd99, 32'd7, 32'd1, 32'd9, 1'b1);
      end else begin
        arm = 1'b0;
      end
      if (c < 14) tick(1);
    end
    chk32("s1_pulse_count", pulse_count, 32'd3);
    chk32("s1_shadow_start", cstart, 32'd10);
    chk1("s1_shadow_dir", cdir, 1'b0);
    chk32("s1_counter_out", out_m, 32'd16);
    chk1("s1_carry_seen", carry_seen, 1'b0);

    // Continuous triggering with PERIOD=0
    load(32'd0, 32'd1, 32'd0, 32'd5, 1'b0);
    do_arm();
    tick(3);
    for (int c = 4; c <= 10; c++) begin
      chk1($sformatf("s2_trig_c%0d", c), trigger, c <= 8);
      chk32($sformatf("s2_count_c%0d", c), pulse_count, (c <= 8) ? 32'(c - 3) : 32'd5);
      chk1($sformatf("s2_done_c%0d", c), done, c == 9);
      if (c < 10) tick(1);
    end
    chk1("s2_busy_end", busy, 1'b0);
    chk32("s2_counter_out", out_m, 32'd5);

    // Abort on the second RUN cycle
    load(32'd0, 32'd1, 32'd10, 32'd4, 1'b0);
    do_arm();
    tick(4);
    chk1("s3_enable_c5", enable, 1'b1);
    chk1("s3_trig_c5", trigger, 1'b0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk1("s3_enable_c6", enable, 1'b0);
    chk1("s3_aborted_c6", aborted, 1'b1);
    chk1("s3_busy_c6", busy, 1'b0);
    chk1("s3_done_c6", done, 1'b0);
    chk32("s3_count_c6", pulse_count, 32'd1);
    for (int c = 7; c <= 18; c++) begin
      tick(1);
      chk1($sformatf("s3_done_c%0d", c), done, 1'b0);
      chk1($sformatf("s3_aborted_c%0d", c), aborted, 1'b0);
      chk1($sformatf("s3_trig_c%0d", c), trigger, 1'b0);
    end
    chk32("s3_count_hold", pulse_count, 32'd1);

    // Abort alone in IDLE, then arm+abort together: both ignored
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk1("s4_idle_abort_pulse", aborted, 1'b0);
    chk1("s4_idle_abort_busy", busy, 1'b0);
    load(32'd3, 32'd3, 32'd1, 32'd2, 1'b0);
    arm = 1'b1;
    abort = 1'b1;
    tick(1);
    arm = 1'b0;
    abort = 1'b0;
    chk1("s4_armabort_busy", busy, 1'b0);
    chk1("s4_armabort_wstb", start_wstb, 1'b0);
    chk32("s4_armabort_count", pulse_count, 32'd1);

    // NPULSES=0: straight to FIN
    load(32'd5, 32'd5, 32'd3, 32'd0, 1'b0);
    do_arm();
    chk1("s4_zero_done_c1", done, 1'b1);
    chk1("s4_zero_busy_c1", busy, 1'b1);
    chk1("s4_zero_wstb_c1", start_wstb, 1'b0);
    chk1("s4_zero_enable_c1", enable, 1'b0);
    chk32("s4_zero_count_c1", pulse_count, 32'd0);
    tick(1);
    chk1("s4_zero_done_c2", done, 1'b0);
    chk1("s4_zero_busy_c2", busy, 1'b0);
    chk1("s4_zero_step_wstb_c2", step_wstb, 1'b0);
    chk1("s4_zero_enable_c2", enable, 1'b0);

    // Carry capture on counter wrap, cleared by the next arm
    load(32'hFFFF_FFFE, 32'd1, 32'd1, 32'd3, 1'b0);
    do_arm();
    tick(4);
    chk1("s5_trig_c5", trigger, 1'b1);
    chk1("s5_seen_c5", carry_seen, 1'b0);
    tick(1);
    chk1("s5_seen_c6", carry_seen, 1'b0);
    tick(1);
    chk1("s5_done_c7", done, 1'b1);
    chk1("s5_seen_c7", carry_seen, 1'b1);
    tick(1);
    chk1("s5_busy_c8", busy, 1'b0);
    chk1("s5_seen_c8", carry_seen, 1'b1);
    chk32("s5_counter_out", out_m, 32'd1);
    load(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    do_arm();
    chk1("s5_seen_cleared", carry_seen, 1'b0);
    tick(1);

    // Asynchronous reset mid-run, then a fresh sequence
    load(32'd10, 32'd2, 32'd4, 32'd3, 1'b0);
    do_arm();
    tick(4);
    chk1("s6_enable_before", enable, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("s6_rst_enable", enable, 1'b0);
    chk1("s6_rst_busy", busy, 1'b0);
    chk1("s6_rst_trig", trigger, 1'b0);
    chk32("s6_rst_start", cstart, 32'd0);
    chk32("s6_rst_step", cstep, 32'd0);
    chk32("s6_rst_count", pulse_count, 32'd0);
    #3 reset_n = 1'b1;
    tick(1);
    load(32'd5, 32'd3, 32'd2, 32'd2, 1'b0);
    do_arm();
    chk1("s6_start_wstb", start_wstb, 1'b1);
    chk32("s6_cnt_start", cstart, 32'd5);
    tick(3);
    for (int c = 4; c <= 8; c++) begin
      chk1($sformatf("s6_trig_c%0d", c), trigger, (c == 4) || (c == 6));
      chk1($sformatf("s6_done_c%0d", c), done, c == 7);
      chk1($sformatf("s6_busy_c%0d", c), busy, c <= 7);
      if (c < 8) tick(1);
    end
    chk32("s6_pulse_count", pulse_count, 32'd2);
    chk32("s6_counter_out", out_m, 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_seq.md
# counter_seq

Sequencer that programs and drives one `counter` block. On an arm pulse it:
- writes START and STEP into the counter through its write strobes;
- enables the counter;
- issues a programmed number of trigger pulses at a fixed period;
- then disables the counter and reports completion.

It sits between the register interface and a single `counter` instance. It replaces hand-driven START_WSTB/STEP_WSTB/enable/trigger stimulus with a deterministic, cycle-exact schedule.

## Interface
- No parameters; all data widths fixed at 32 bits.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `arm_i`  in  1  single-cycle pulse that starts a sequence.
- `abort_i`  in  1  single-cycle pulse that terminates a sequence.
- `START`  in  32  counter start value.
- `STEP`  in  32  counter step value.
- `PERIOD`  in  32  cycles between triggers; 0 is treated as 1.
- `NPULSES`  in  32  number of triggers to issue.
- `DIR`  in  1  count direction passed to the counter.
- `carry_i`  in  1  `carry_o` of the driven counter.
- `cnt_enable_o`  out  1  to counter `enable_i`.
- `cnt_trigger_o`  out  1  to counter `trigger_i`.
- `cnt_dir_o`  out  1  to counter `dir_i`.
- `cnt_start_o`  out  32  to counter `START`.
- `cnt_start_wstb_o`  out  1  to counter `START_WSTB`.
- `cnt_step_o`  out  32  to counter `STEP`.
- `cnt_step_wstb_o`  out  1  to counter `STEP_WSTB`.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse on normal completion.
- `aborted_o`  out  1  one-cycle pulse on abort.
- `carry_seen_o`  out  1  sticky; set if `carry_i` is high while enabled.
- `pulse_count_o`  out  32  number of triggers issued in the current or last sequence.

## Operation
- Shadow registers:
  - In IDLE, `arm_i` captures START, STEP, PERIOD, NPULSES and DIR into shadows.
  - Input changes after arm have no effect until the next arm.
  - `cnt_start_o`, `cnt_step_o` and `cnt_dir_o` are driven from the shadows.
- States: IDLE, LD_START, LD_STEP, ENA, RUN, FIN.
- Transitions:
  - IDLE --arm, NPULSES≠0--> LD_START.
  - IDLE --arm, NPULSES=0--> FIN. No strobes, no enable; `done_o` still pulses.
  - LD_START (`cnt_start_wstb_o`=1) --> LD_STEP.
  - LD_STEP (`cnt_step_wstb_o`=1) --> ENA.
  - ENA (enable rises) --> RUN.
  - RUN --last trigger--> FIN.
  - FIN (`done_o`=1) --> IDLE.
- Enable: `cnt_enable_o` is 1 in ENA, RUN and FIN (FIN only when entered from RUN); 0 elsewhere.
- RUN trigger scheduling:
  - First trigger is on the first RUN cycle.
  - A 32-bit down-counter reloads with PERIOD−1 after each trigger; the next trigger fires when it reaches 0.
  - PERIOD of 0 or 1 gives a trigger every cycle.
- RUN pulse counting:
  - `pulse_count_o` increments on each trigger cycle.
  - When the count reaches NPULSES, RUN exits after that trigger.
- Abort:
  - `abort_i` in any non-IDLE state forces IDLE on the next edge.
  - On that edge: enable, trigger and strobes go to 0, `aborted_o` pulses one cycle, `done_o` does not pulse.
  - `pulse_count_o` holds its value.
- Ignored inputs:
  - `abort_i` in IDLE is ignored.
  - `arm_i` while busy is ignored.
  - `arm_i` and `abort_i` in the same IDLE cycle: abort wins and the arm is ignored.
- Status clearing: arm clears `carry_seen_o` and `pulse_count_o` to 0.
- Carry capture: `carry_seen_o` sets on any cycle where `cnt_enable_o`=1 and `carry_i`=1; it stays set until the next arm or reset.

## Timing
- Reset (asynchronous, effective immediately, including mid-sequence):
  - State goes to IDLE.
  - Every output is 0, including `cnt_start_o`, `cnt_step_o` and the shadows.
- Cycle schedule, with arm sampled at edge 0:
  - Cycle 1: LD_START, `cnt_start_wstb_o`=1, `busy_o`=1.
  - Cycle 2: LD_STEP, `cnt_step_wstb_o`=1.
  - Cycle 3: ENA, `cnt_enable_o`=1.
  - Cycle 4: first `cnt_trigger_o`.
  - Trigger k (k=1..N) occurs at cycle 4+(k−1)·P, with P=max(PERIOD,1).
  - Cycle T+1, where T is the last trigger cycle: FIN, `done_o`=1, enable still 1.
  - Cycle T+2: IDLE, enable=0, `busy_o`=0. A new arm is accepted in this cycle.
- NPULSES=0: arm at edge 0 gives FIN with `done_o`=1 at cycle 1, then IDLE at cycle 2.
- Output registration:
  - `cnt_trigger_o` and the strobes are exactly one cycle wide.
  - All outputs are registered; there is no combinational path from input to output.
- Width rules:
  - `pulse_count_o` and the period counter are 32-bit unsigned.
  - NPULSES up to 2^32−1 is supported; the count never wraps within a sequence.

## Test plan
- Basic sequence: START=10, STEP=2, PERIOD=4, NPULSES=3, DIR=0, arm at ts 100.
  - Strobes at ts 101 and 102; enable from ts 103.
  - Triggers at 104, 108, 112; `done_o` at 113; enable low at 114.
  - Driven counter `out_o` ends at 16.
- Continuous triggering: PERIOD=0, NPULSES=5 gives triggers on 5 consecutive cycles starting at arm+4; `pulse_count_o`=5.
- Abort mid-run: abort_i at the second RUN cycle with PERIOD=10, NPULSES=4.
  - Next cycle: enable=0 and `aborted_o`=1.
  - `done_o` never pulses; `pulse_count_o`=1.
- Ignored and zero-length arms:
  - Arm while busy, and registers changed mid-run: the schedule is unchanged.
  - NPULSES=0: `done_o` at arm+1 with no strobes or enable.
- Carry capture: START=0xFFFFFFFE, STEP=1, NPULSES=3 gives `carry_seen_o`=1 after the overflow; the next arm clears it.
- Reset mid-run: `reset_n_i` low during RUN drops all outputs to 0 asynchronously (before the next edge); after release, a fresh arm runs the full schedule.
